// File: rtl/rle_expander.sv
// ---------------------------------------------------------------------------
// rle_expander
//
// Turns decoded JPEG Huffman symbols (run/size/additional bits) into the 64
// signed coefficients of one 8x8 block, in zigzag order. It applies a
// separate DC prediction for each colour component. Coefficients are written
// one per cycle into the write port of zigzag_to_matrix.
//
// Ports
//   i_sysclk            system clock, rising edge
//   i_arst              asynchronous active-low reset
//   i_srst              synchronous restart (RSTn marker): clears the
//                       predictors, the state and the error flag
//   i_sym_valid         symbol present
//   o_sym_ready         symbol taken when valid & ready on a rising edge
//   i_comp              component of the block (sampled with the DC symbol)
//   i_run / i_size      zero run and size category of the symbol
//   i_amp               additional bits, right-aligned
//   o_we                write strobe (pending coefficient and not full)
//   o_data / o_idx      coefficient and its zigzag index
//   o_last              high together with o_we for index 63
//   i_full              downstream full; stalls the output
//   o_err               sticky error flag (illegal size or block overrun)
// ---------------------------------------------------------------------------
module rle_expander #(
    parameter int AMPLITUDE_PRECISION = 16,
    parameter int NUM_CHANNEL         = 3,
    parameter int MAX_SIZE            = 11
) (
    input  logic                           i_sysclk,
    input  logic                           i_arst,
    input  logic                           i_srst,
    input  logic                           i_sym_valid,
    output logic                           o_sym_ready,
    input  logic [1:0]                     i_comp,
    input  logic [3:0]                     i_run,
    input  logic [3:0]                     i_size,
    input  logic [10:0]                    i_amp,
    output logic                           o_we,
    output logic [AMPLITUDE_PRECISION-1:0] o_data,
    output logic [5:0]                     o_idx,
    output logic                           o_last,
    input  logic                           i_full,
    output logic                           o_err
);
    localparam int         AP       = AMPLITUDE_PRECISION;
    localparam logic [3:0] DC_LIMIT = 4'(MAX_SIZE);
    localparam logic [3:0] AC_LIMIT = 4'd10;
    localparam logic [5:0] LAST_IDX = 6'd63;

    typedef enum logic [2:0] {
        S_DC   = 3'd0,
        S_AC   = 3'd1,
        S_ZERO = 3'd2,
        S_COEF = 3'd3,
        S_FILL = 3'd4
    } state_t;

    // An illegal size is processed at the largest legal width.
    function automatic logic [3:0] clamp_size(input logic [3:0] size,
                                              input logic [3:0] limit);
        logic [3:0] res;
        if (size > limit) begin
            res = limit;
        end else begin
            res = size;
        end
        return res;
    endfunction

    // JPEG amplitude decode. A clear top bit means the value is negative:
    // amp - (2^s - 1).
    function automatic logic [AP-1:0] decode_amp(input logic [3:0]  size,
                                                 input logic [10:0] amp);
        logic [AP-1:0] mask;
        logic [AP-1:0] bits;
        logic [AP-1:0] res;
        mask = (AP'(1) << size) - AP'(1);
        bits = AP'(amp) & mask;
        if (size == 4'd0) begin
            res = '0;
        end else if (bits[size - 4'd1]) begin
            res = bits;
        end else begin
            res = bits - mask;
        end
        return res;
    endfunction

    state_t        state_q, state_d;
    logic [5:0]    gen_idx_q, gen_idx_d;
    logic [3:0]    zeros_q, zeros_d;
    logic [AP-1:0] coef_q, coef_d;
    logic          has_coef_q, has_coef_d;
    logic [AP-1:0] pred_q [NUM_CHANNEL];
    logic [AP-1:0] pred_d [NUM_CHANNEL];
    logic          err_q, err_d;
    logic          pending_q, pending_d;
    logic [AP-1:0] data_q, data_d;
    logic [5:0]    idx_q, idx_d;
    logic          last_q, last_d;

    logic          we_s;
    logic          adv_s;
    logic          accept_s;
    logic          at_end_s;
    logic          load_s;
    logic [AP-1:0] load_val_s;
    logic [AP-1:0] dc_dec_s;
    logic [AP-1:0] ac_dec_s;
    logic          comp_ok_s;

    assign we_s      = pending_q & ~i_full;
    // The output slot can take a new coefficient when it is empty or is
    // being written this cycle. This allows one coefficient per cycle.
    assign adv_s     = ~pending_q | we_s;
    assign accept_s  = i_sym_valid & o_sym_ready;
    assign at_end_s  = (gen_idx_q == LAST_IDX);
    assign dc_dec_s  = decode_amp(clamp_size(i_size, DC_LIMIT), i_amp);
    assign ac_dec_s  = decode_amp(clamp_size(i_size, AC_LIMIT), i_amp);
    assign comp_ok_s = (int'(i_comp) < NUM_CHANNEL);

    assign o_sym_ready = i_arst & ~i_srst & adv_s &
                         ((state_q == S_DC) | (state_q == S_AC));
    assign o_we   = we_s;
    assign o_data = data_q;
    assign o_idx  = idx_q;
    assign o_last = we_s & last_q;
    assign o_err  = err_q;

    // Next-state, coefficient generation and restart handling
    always_comb begin
        state_d    = state_q;
        gen_idx_d  = gen_idx_q;
        zeros_d    = zeros_q;
        coef_d     = coef_q;
        has_coef_d = has_coef_q;
        pred_d     = pred_q;
        err_d      = err_q;
        pending_d  = pending_q & ~we_s;
        data_d     = data_q;
        idx_d      = idx_q;
        last_d     = last_q;
        load_s     = 1'b0;
        load_val_s = '0;

        case (state_q)
            S_DC: begin
                if (accept_s) begin
                    load_s  = 1'b1;
                    err_d   = err_q | (i_size > DC_LIMIT) | ~comp_ok_s;
                    state_d = S_AC;
                    if (comp_ok_s) begin
                        pred_d[i_comp] = pred_q[i_comp] + dc_dec_s;
                        load_val_s     = pred_q[i_comp] + dc_dec_s;
                    end else begin
                        load_val_s = dc_dec_s;
                    end
                end else begin
                    state_d = S_DC;
                end
            end
            S_AC: begin
                if (accept_s) begin
                    // The first coefficient of a symbol is emitted in the cycle
                    // the symbol is taken, so there is no gap in the output.
                    load_s = 1'b1;
                    err_d  = err_q | (i_size > AC_LIMIT);
                    if ((i_run == 4'd0) && (i_size == 4'd0)) begin
                        state_d = at_end_s ? S_DC : S_FILL;
                    end else if ((i_run == 4'd15) && (i_size == 4'd0)) begin
                        zeros_d    = 4'd15;
                        has_coef_d = 1'b0;
                        if (at_end_s) begin
                            err_d   = 1'b1;
                            state_d = S_DC;
                        end else begin
                            state_d = S_ZERO;
                        end
                    end else if (i_run == 4'd0) begin
                        load_val_s = ac_dec_s;
                        state_d    = at_end_s ? S_DC : S_AC;
                    end else begin
                        coef_d     = ac_dec_s;
                        zeros_d    = i_run - 4'd1;
                        has_coef_d = 1'b1;
                        if (at_end_s) begin
                            err_d   = 1'b1;
                            state_d = S_DC;
                        end else if (i_run == 4'd1) begin
                            state_d = S_COEF;
                        end else begin
                            state_d = S_ZERO;
                        end
                    end
                end else begin
                    state_d = S_AC;
                end
            end
            S_ZERO: begin
                if (adv_s) begin
                    load_s  = 1'b1;
                    zeros_d = zeros_q - 4'd1;
                    if (at_end_s) begin
                        // Zeros or a value still owed past index 63 are dropped.
                        err_d   = err_q | (zeros_q > 4'd1) | has_coef_q;
                        state_d = S_DC;
                    end else if (zeros_q == 4'd1) begin
                        state_d = has_coef_q ? S_COEF : S_AC;
                    end else begin
                        state_d = S_ZERO;
                    end
                end else begin
                    state_d = S_ZERO;
                end
            end
            S_COEF: begin
                if (adv_s) begin
                    load_s     = 1'b1;
                    load_val_s = coef_q;
                    state_d    = at_end_s ? S_DC : S_AC;
                end else begin
                    state_d = S_COEF;
                end
            end
            S_FILL: begin
                if (adv_s) begin
                    load_s  = 1'b1;
                    state_d = at_end_s ? S_DC : S_FILL;
                end else begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_DC;
            end
        endcase

        if (load_s) begin
            pending_d = 1'b1;
            data_d    = load_val_s;
            idx_d     = gen_idx_q;
            last_d    = at_end_s;
            gen_idx_d = gen_idx_q + 6'd1;   // wraps to 0 after index 63
        end else begin
            gen_idx_d = gen_idx_q;
        end

        if (i_srst) begin
            state_d    = S_DC;
            gen_idx_d  = 6'd0;
            zeros_d    = 4'd0;
            coef_d     = '0;
            has_coef_d = 1'b0;
            err_d      = 1'b0;
            pending_d  = 1'b0;
            data_d     = '0;
            idx_d      = 6'd0;
            last_d     = 1'b0;
            for (int i = 0; i < NUM_CHANNEL; i++) begin
                pred_d[i] = '0;
            end
        end else begin
            err_d = err_d;
        end
    end

    // State, predictor and output registers
    always_ff @(posedge i_sysclk or negedge i_arst) begin
        if (!i_arst) begin
            state_q    <= S_DC;
            gen_idx_q  <= 6'd0;
            zeros_q    <= 4'd0;
            coef_q     <= '0;
            has_coef_q <= 1'b0;
            err_q      <= 1'b0;
            pending_q  <= 1'b0;
            data_q     <= '0;
            idx_q      <= 6'd0;
            last_q     <= 1'b0;
            for (int i = 0; i < NUM_CHANNEL; i++) begin
                pred_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            gen_idx_q  <= gen_idx_d;
            zeros_q    <= zeros_d;
            coef_q     <= coef_d;
            has_coef_q <= has_coef_d;
            err_q      <= err_d;
            pending_q  <= pending_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            pred_q     <= pred_d;
        end
    end

endmodule

// File: tb/tb_rle_expander.sv
// ---------------------------------------------------------------------------
// Testbench for rle_expander. The stimulus pushes hand-computed blocks of
// 64 expected coefficients into a queue. A monitor pops one entry and
// compares it on every write strobe.
// ---------------------------------------------------------------------------
module tb_rle_expander;
    logic        clk = 1'b0;
    logic        arst;
    logic        srst;
    logic        sym_valid;
    logic        sym_ready;
    logic [1:0]  comp;
    logic [3:0]  run;
    logic [3:0]  size;
    logic [10:0] amp;
    logic        we;
    logic [15:0] data;
    logic [5:0]  idx;
    logic        last;
    logic        full;
    logic        err;

    rle_expander #(
        .AMPLITUDE_PRECISION(16),
        .NUM_CHANNEL(3),
        .MAX_SIZE(11)
    ) dut (
        .i_sysclk   (clk),
        .i_arst     (arst),
        .i_srst     (srst),
        .i_sym_valid(sym_valid),
        .o_sym_ready(sym_ready),
        .i_comp     (comp),
        .i_run      (run),
        .i_size     (size),
        .i_amp      (amp),
        .o_we       (we),
        .o_data     (data),
        .o_idx      (idx),
        .o_last     (last),
        .i_full     (full),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  idx;
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] blk [64];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t0 = 0;
    bit          mon_en = 1'b1;
    bit          gap_en = 1'b1;
    bit          rand_full = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard compare on every write, plus full/gap checks.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (full) begin
                checks++;
                if (we) begin
                    errors++;
                    $display("FAIL we_while_full got o_we=%b required 0", we);
                end
            end
            if (we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got idx=%0d data=%h, required no write", idx, data);
                end else begin
                    e = exp_q.pop_front();
                    if (idx !== e.idx || data !== e.data || last !== e.last) begin
                        errors++;
                        $display("FAIL coef got idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                                 idx, data, last, e.idx, e.data, e.last);
                    end
                end
                if (idx == 6'd0) t0 = cyc;
                if (last && gap_en) begin
                    checks++;
                    if (cyc - t0 != 63) begin
                        errors++;
                        $display("FAIL block_gapless got %0d cycles idx0..63 required 63", cyc - t0);
                    end
                end
            end
        end
    end

    // Downstream full: random when enabled, changes away from the edges.
    initial begin
        full = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            full = rand_full ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic blk_init(input logic [15:0] dc);
        for (int i = 0; i < 64; i++) blk[i] = 16'h0000;
        blk[0] = dc;
    endtask

    task automatic blk_push();
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            e.idx  = 6'(i);
            e.data = blk[i];
            e.last = (i == 63);
            exp_q.push_back(e);
        end
    endtask

    // Called and returns at posedge+1; the symbol is held until it is taken.
    task automatic send(input logic [1:0] c, input logic [3:0] r,
                        input logic [3:0] s, input logic [10:0] a);
        int n;
        bit done;
        comp = c; run = r; size = s; amp = a; sym_valid = 1'b1;
        n = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (sym_ready) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 300) begin
                    checks++; errors++;
                    $display("FAIL send_timeout got no ready in %0d cycles required ready", n);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        sym_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d entries left required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic ac_seq();
        send(2'd0, 4'd0, 4'd2, 11'd0);
        send(2'd0, 4'd1, 4'd2, 11'd3);
        send(2'd0, 4'd15, 4'd0, 11'd0);
        send(2'd0, 4'd0, 4'd1, 11'd1);
        send(2'd0, 4'd0, 4'd0, 11'd0);
    endtask

    initial begin
        arst = 1'b0; srst = 1'b0; sym_valid = 1'b0;
        comp = 2'd0; run = 4'd0; size = 4'd0; amp = 11'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_we", 32'(we), 32'd0);
        chk("reset_last", 32'(last), 32'd0);
        chk("reset_idx", 32'(idx), 32'd0);
        chk("reset_data", 32'(data), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_ready", 32'(sym_ready), 32'd0);
        #1 arst = 1'b1;
        @(posedge clk);
        #1;

        // DC -26 on comp0, then EOB
        blk_init(16'hFFE6); blk_push();
        send(2'd0, 4'd0, 4'd5, 11'b00101);
        send(2'd0, 4'd0, 4'd0, 11'd0);
        // comp0 again, diff +3 -> -23
        blk_init(16'hFFE9); blk_push();
        send(2'd0, 4'd0, 4'd2, 11'b11);
        send(2'd0, 4'd0, 4'd0, 11'd0);
        // comp1 has its own predictor -> -26
        blk_init(16'hFFE6); blk_push();
        send(2'd1, 4'd0, 4'd5, 11'b00101);
        send(2'd0, 4'd0, 4'd0, 11'd0);
        // AC sequence on comp2 (DC diff 0)
        blk_init(16'h0000); blk[1] = 16'hFFFD; blk[3] = 16'h0003; blk[20] = 16'h0001; blk_push();
        send(2'd2, 4'd0, 4'd0, 11'd0);
        ac_seq();
        wait_drain();

        // Same block with random back-pressure
        rand_full = 1'b1; gap_en = 1'b0;
        blk_push();
        send(2'd2, 4'd0, 4'd0, 11'd0);
        ac_seq();
        wait_drain();
        rand_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        gap_en = 1'b1;

        // Overrun: (15,1) at idx60; comp0 DC +1 -> -22
        blk_init(16'hFFEA); blk[59] = 16'h0001; blk_push();
        send(2'd0, 4'd0, 4'd1, 11'd1);
        repeat (3) send(2'd0, 4'd15, 4'd0, 11'd0);
        send(2'd0, 4'd10, 4'd1, 11'd1);
        send(2'd0, 4'd15, 4'd1, 11'd1);
        wait_drain();
        chk("overrun_err", 32'(err), 32'd1);
        // Next symbol is DC: -1 -> -23
        blk_init(16'hFFE9); blk_push();
        send(2'd0, 4'd0, 4'd1, 11'd0);
        send(2'd0, 4'd0, 4'd0, 11'd0);
        wait_drain();
        chk("err_sticky", 32'(err), 32'd1);

        // Synchronous restart
        srst = 1'b1;
        @(negedge clk);
        chk("srst_ready", 32'(sym_ready), 32'd0);
        @(posedge clk);
        #1;
        srst = 1'b0;
        chk("srst_err", 32'(err), 32'd0);
        blk_init(16'h0002); blk_push();
        send(2'd0, 4'd0, 4'd2, 11'b10);
        send(2'd0, 4'd0, 4'd0, 11'd0);

        // Exact fill to 63 without EOB, then DC on comp1 -> 4
        blk_init(16'h0000); blk[63] = 16'h0001; blk_push();
        send(2'd1, 4'd0, 4'd0, 11'd0);
        repeat (3) send(2'd0, 4'd15, 4'd0, 11'd0);
        send(2'd0, 4'd14, 4'd1, 11'd1);
        blk_init(16'h0004); blk_push();
        send(2'd1, 4'd0, 4'd3, 11'b100);
        send(2'd0, 4'd0, 4'd0, 11'd0);
        wait_drain();
        chk("exact_fill_err", 32'(err), 32'd0);

        // Illegal DC size 12 on comp2: processed as size 11 -> 1024
        blk_init(16'h0400); blk_push();
        send(2'd2, 4'd0, 4'd12, 11'h400);
        send(2'd0, 4'd0, 4'd0, 11'd0);
        wait_drain();
        chk("illegal_size_err", 32'(err), 32'd1);

        // Asynchronous reset in the middle of a zero run
        mon_en = 1'b0;
        send(2'd0, 4'd0, 4'd0, 11'd0);
        send(2'd0, 4'd15, 4'd0, 11'd0);
        #2;
        chk("zero_run_we", 32'(we), 32'd1);
        arst = 1'b0;
        #1;
        chk("arst_we_drop", 32'(we), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        arst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("post_arst_ready", 32'(sym_ready), 32'd1);
        @(posedge clk);
        #1;
        // Predictor cleared: diff -2 -> -2
        blk_init(16'hFFFE); blk_push();
        send(2'd0, 4'd0, 4'd2, 11'b01);
        send(2'd0, 4'd0, 4'd0, 11'd0);
        wait_drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rle_expander.md
Name: rle_expander

Overview:
- Entropy-side stage that sits directly upstream of zigzag_to_matrix in the JPEG viewer pipeline.
- Consumes decoded Huffman symbols (run/size/additional-bits) per 8x8 block.
- Applies DC differential prediction per colour component and expands runs and EOB/ZRL into exactly 64 signed coefficients in zigzag order.
- Writes the coefficients one per cycle into the zigzag_to_matrix write port, which has a we/full interface.

Parameters:
- AMPLITUDE_PRECISION, 16, width of output coefficient (two's complement).
- NUM_CHANNEL, 3, number of components with an independent DC predictor (Y, U, V).
- MAX_SIZE, 11, largest legal size category; larger values raise o_err.

Ports:
- i_sysclk  in  1  system clock; all logic rising-edge.
- i_arst  in  1  asynchronous, active-low reset (asserts immediately when low, released synchronously to i_sysclk).
- i_srst  in  1  synchronous active-high restart; clears DC predictors and state (JPEG RSTn marker).
- i_sym_valid  in  1  symbol present.
- o_sym_ready  out  1  symbol accepted when valid&ready on the rising edge.
- i_comp  in  2  component index of the block the symbol belongs to; sampled with the DC symbol only.
- i_run  in  4  zero run (AC only; ignored for DC).
- i_size  in  4  size category.
- i_amp  in  11  additional bits, right-aligned; only the low i_size bits are meaningful.
- o_we  out  1  coefficient write strobe to zigzag_to_matrix.
- o_data  out  AMPLITUDE_PRECISION  coefficient.
- o_idx  out  6  zigzag index of o_data (0..63).
- o_last  out  1  high with o_we when o_idx==63.
- i_full  in  1  downstream full; stalls output.
- o_err  out  1  sticky error flag; cleared by reset or i_srst.

Behaviour:
- Reset (i_arst low or i_srst high): state S_DC, idx=0, all predictors=0, o_sym_ready=0 for the reset cycle, internal pending=0 (o_we=0, o_last=0), o_data=0, o_idx=0, o_err=0.
- Amplitude decode, with s=i_size:
  - s==0 gives 0.
  - Otherwise, if amp[s-1]==1 the value is amp, else the value is amp-(2^s-1).
  - The result is sign-extended to AMPLITUDE_PRECISION.
- Output handshake:
  - o_we = pending & ~i_full (combinational from registers and i_full).
  - The coefficient advances only when o_we=1; o_data, o_idx and o_last hold while stalled.
- o_sym_ready is high only in S_DC or S_AC, and only when pending==0 or the pending coefficient is being written this cycle. This gives a sustained 1 coefficient/cycle.
- Latency: symbol accepted in cycle N makes its first coefficient pending in cycle N+1.
- S_DC:
  - On accept: pred[i_comp] += decode(size,amp), with wrap modulo 2^AMPLITUDE_PRECISION.
  - Latch the component, emit the new pred at idx 0, then go to S_AC.
- S_AC, on accept, dispatch on (run,size):
  - (0,0) EOB: go to S_FILL.
  - (15,0) ZRL: zeros=16, go to S_ZERO, followed by no coefficient.
  - Otherwise: zeros=run, go to S_ZERO, followed by S_COEF with the decoded value.
- S_ZERO: emits one 0 per written cycle; run==0 passes straight to S_COEF in the same cycle.
- S_COEF: emits the value, then returns to S_AC.
- S_FILL: emits 0 until idx 63 is written.
- Block end: on any write with idx==63, assert o_last, go to S_DC, reset idx=0.
  - Symbols remaining in a zero run or value are discarded.
  - If the run or value overran index 63, set o_err.
- Illegal sizes: size>MAX_SIZE for DC, or size>10 for AC, sets o_err. The symbol is processed with its amp bits truncated to the legal width.
- An AC symbol completing index 63 exactly (no EOB) is legal. The next symbol is treated as DC.
- i_srst mid-block: aborts the block immediately. No further writes happen; the partial block in downstream is the system's responsibility.

Test Plan:
- DC size5 amp=5'b00101 comp0 then EOB -> idx0 = -26 (0xFFE6), idx1..63 = 0, o_last at idx63, 64 consecutive o_we cycles.
- Same block fed twice on comp0 with the second DC diff = size2 amp=2'b11 (+3) -> second block idx0 = -23; the comp1 block DC diff -26 -> -26 (independent predictor).
- AC sequence (0,2,amp0)(1,2,amp3)(15,0)(0,1,amp1) EOB -> the coefficients are:
  - idx1 = -3
  - idx2 = 0, idx3 = +3
  - idx4..19 = 0
  - idx20 = +1
  - remaining = 0
- Randomised i_full toggling during the above -> the written data sequence is identical and there are no duplicated or dropped indices; o_data/o_idx are stable while stalled.
- AC (15,1) at idx60 -> writes 0 at idx 60..63, o_last, o_err=1; the next symbol is decoded as DC; i_srst clears o_err and the predictors.
- i_arst pulsed low mid-S_ZERO -> o_we drops asynchronously; after release, o_sym_ready=1 and the next symbol is treated as DC with pred=0.
